// File: rtl/pc_control_if.sv
// Decode/PC-stage bundle for pc_control: instruction fields in, fetch address and branch status out.
// master = decode side driving the instruction fields; slave = pc_control.
interface pc_control_if;
    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] rs_data;
    logic [2:0]  flags;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        flush;
    logic        halted;

    modport master (
        output opcode, cond, imm9, rs_data, flags, stall,
        input  pc, pc_plus2, taken, flush, halted
    );

    modport slave (
        input  opcode, cond, imm9, rs_data, flags, stall,
        output pc, pc_plus2, taken, flush, halted
    );
endinterface

// File: rtl/pc_control.sv
// Program-counter stage: PC register, B/BR/PCS/HLT resolution and a RUN/HALTED state machine.
// Optional macro PC_BRANCH_STATS_EN adds br_count/br_seen saturating branch counters.
module pc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    pc_control_if.slave     bus
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]     br_count,
    output logic [15:0]     br_seen
`endif
);

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] pc_q;
    logic        flush_q;
    logic [15:0] pc_plus2;
    logic [15:0] br_offset;
    logic [15:0] pc_next;
    logic        cond_true;
    logic        is_branch;
    logic        is_hlt;
    logic        active;
    logic        taken;
    logic        flag_v;
    logic        flag_n;
    logic        flag_z;

    assign flag_v = bus.flags[2];
    assign flag_n = bus.flags[1];
    assign flag_z = bus.flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            3'b000:  cond_true = !flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = !flag_z && !flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z || (!flag_z && !flag_n);
            3'b101:  cond_true = flag_n || flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    assign pc_plus2  = pc_q + 16'd2;
    // imm9 counts instructions: sign-extend then scale by 2 bytes.
    assign br_offset = {{6{bus.imm9[8]}}, bus.imm9, 1'b0};
    assign active    = (state == RUN) && !bus.stall;
    assign is_branch = (bus.opcode == OP_B) || (bus.opcode == OP_BR);
    assign is_hlt    = (bus.opcode == OP_HLT);
    assign taken     = is_branch && cond_true && active;

    always_comb begin
        pc_next = pc_plus2;
        if (taken) begin
            pc_next = (bus.opcode == OP_B) ? (pc_plus2 + br_offset) : bus.rs_data;
        end else if (is_hlt) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state   <= RUN;
            flush_q <= 1'b0;
        end else begin
            flush_q <= taken;
            if (active) begin
                pc_q <= pc_next;
                if (is_hlt) begin
                    state <= HALTED;
                end
            end
        end
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            br_count <= '0;
            br_seen  <= '0;
        end else if (active && is_branch) begin
            if (br_seen != '1) begin
                br_seen <= br_seen + 16'd1;
            end
            if (taken && (br_count != '1)) begin
                br_count <= br_count + 16'd1;
            end
        end
    end
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus2 = pc_plus2;
    assign bus.taken    = taken;
    assign bus.flush    = flush_q;
    assign bus.halted   = (state == HALTED);

endmodule
